// File: rtl/pc_update.sv
// PC-update stage of the sequential Y86-64 processor.
// Picks the next program counter from the instruction class and the stage
// values, then registers it as the architectural PC. Also registers whether
// the captured instruction was halt or an invalid opcode.
module pc_update #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [WIDTH-1:0] valC,
  input  logic [WIDTH-1:0] valP,
  input  logic [WIDTH-1:0] valM,
  output logic [WIDTH-1:0] pcnxt,
  output logic             halted,
  output logic             instr_err
);

  // Y86-64 instruction codes; 0xC..0xF are unassigned and treated as invalid.
  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_CMOVXX = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  icode_e           op;
  logic [WIDTH-1:0] next_pc;
  logic             halted_next;
  logic             instr_err_next;

  assign op = icode_e'(icode);

  // Next-PC selection. cnd is only looked at for jXX, so an unknown cnd
  // cannot leak into the PC for any other instruction.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    next_pc        = pcnxt;
    halted_next    = 1'b0;
    instr_err_next = 1'b0;
    case (op)
      I_HALT:   halted_next = 1'b1;
      I_NOP, I_CMOVXX, I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
                next_pc = valP;
      I_JXX:    next_pc = cnd ? valC : valP;
      I_CALL:   next_pc = valC;
      I_RET:    next_pc = valM;
      default:  instr_err_next = 1'b1;
    endcase
  end

  // Architectural PC and status flags; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnxt     <= RESET_PC;
      halted    <= 1'b0;
      instr_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all three registers update together
      // from the values present before the edge.
      pcnxt     <= next_pc;
      halted    <= halted_next;
      instr_err <= instr_err_next;
    end
  end

endmodule

// File: tb/tb_pc_update.sv
// Self-checking bench for pc_update: reset behaviour, a table of directed
// vectors, a randomised run against a small reference model, and hand-written
// sequences for asynchronous and edge-coincident reset.
module tb_pc_update;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             rst_n;
  logic [3:0]       icode;
  logic             cnd;
  logic [WIDTH-1:0] valC;
  logic [WIDTH-1:0] valP;
  logic [WIDTH-1:0] valM;
  logic [WIDTH-1:0] pcnxt;
  logic             halted;
  logic             instr_err;

  pc_update #(.WIDTH(WIDTH), .RESET_PC('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .icode     (icode),
    .cnd       (cnd),
    .valC      (valC),
    .valP      (valP),
    .valM      (valM),
    .pcnxt     (pcnxt),
    .halted    (halted),
    .instr_err (instr_err)
  );

  // Stimulus vector with its expected registered result.
  typedef struct {
    logic [3:0]       icode;
    logic             cnd;
    logic [WIDTH-1:0] valC;
    logic [WIDTH-1:0] valP;
    logic [WIDTH-1:0] valM;
    logic [WIDTH-1:0] exp_pc;
    logic             exp_halted;
    logic             exp_err;
  } vec_t;

  // Scoreboard entry: what the DUT must show after the next edge.
  typedef struct {
    logic [WIDTH-1:0] pc;
    logic             halted;
    logic             err;
    int               tag;
  } exp_t;

  vec_t             vecs[$];
  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] last_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] ic, input logic c,
                         input logic [WIDTH-1:0] vc, input logic [WIDTH-1:0] vp,
                         input logic [WIDTH-1:0] vm, input logic [WIDTH-1:0] epc,
                         input logic eh, input logic ee);
    vec_t v;
    v.icode = ic; v.cnd = c; v.valC = vc; v.valP = vp; v.valM = vm;
    v.exp_pc = epc; v.exp_halted = eh; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // Drive one instruction at the falling edge and queue its expected result.
  task automatic drive(input logic [3:0] ic, input logic c,
                       input logic [WIDTH-1:0] vc, input logic [WIDTH-1:0] vp,
                       input logic [WIDTH-1:0] vm, input logic [WIDTH-1:0] epc,
                       input logic eh, input logic ee, input int tag);
    exp_t e;
    @(negedge clk);
    icode = ic; cnd = c; valC = vc; valP = vp; valM = vm;
    e.pc = epc; e.halted = eh; e.err = ee; e.tag = tag;
    sb.push_back(e);
    // Output must not move before the edge.
    #1 check($sformatf("hold_before_edge[%0d]", tag), pcnxt, last_pc);
    last_pc = epc;
  endtask

  // Let one edge pass and compare against the oldest scoreboard entry.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check($sformatf("pc[%0d]", e.tag), pcnxt, e.pc);
      check($sformatf("halted[%0d]", e.tag), {63'd0, halted}, {63'd0, e.halted});
      check($sformatf("instr_err[%0d]", e.tag), {63'd0, instr_err}, {63'd0, e.err});
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_pc"}, pcnxt, 64'd0);
    check({name, "_halted"}, {63'd0, halted}, 64'd0);
    check({name, "_err"}, {63'd0, instr_err}, 64'd0);
  endtask

  initial begin
    logic [3:0]       r_ic;
    logic             r_c;
    logic [WIDTH-1:0] r_vc, r_vp, r_vm, r_pc;
    logic             r_h, r_e;

    // Directed table: chains from pcnxt=0x40 after reset release.
    add_vec(4'h1, 1'b0, 64'h111, 64'h0A, 64'h222, 64'h0A, 0, 0);
    add_vec(4'hA, 1'b1, 64'h333, 64'h0C, 64'h444, 64'h0C, 0, 0);
    add_vec(4'h7, 1'b1, 64'h100, 64'h09, 64'h555, 64'h100, 0, 0);
    add_vec(4'h7, 1'b0, 64'h100, 64'h09, 64'h555, 64'h09, 0, 0);
    add_vec(4'h8, 1'b0, 64'h200, 64'h0B, 64'h666, 64'h200, 0, 0);
    add_vec(4'h9, 1'b1, 64'h777, 64'h0D, 64'h13, 64'h13, 0, 0);
    add_vec(4'h0, 1'b0, 64'h888, 64'h14, 64'h999, 64'h13, 1, 0);
    add_vec(4'hE, 1'b1, 64'hAAA, 64'h15, 64'hBBB, 64'h13, 0, 1);
    add_vec(4'h1, 1'b0, 64'hCCC, 64'h20, 64'hDDD, 64'h20, 0, 0);
    add_vec(4'h9, 1'b0, 64'h1, 64'h2, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
    add_vec(4'h3, 1'b1, 64'h999, 64'h28, 64'h31, 64'h28, 0, 0);
    add_vec(4'hB, 1'bx, 64'h35, 64'h30, 64'h36, 64'h30, 0, 0);
    add_vec(4'h8, 1'bx, 64'hDEAD_BEEF_0000_1234, 64'h38, 64'h39, 64'hDEAD_BEEF_0000_1234, 0, 0);
    add_vec(4'hC, 1'b1, 64'h41, 64'h44, 64'h42, 64'hDEAD_BEEF_0000_1234, 0, 1);
    add_vec(4'hF, 1'b0, 64'h43, 64'h45, 64'h46, 64'hDEAD_BEEF_0000_1234, 0, 1);
    add_vec(4'h0, 1'bx, 64'h47, 64'h48, 64'h49, 64'hDEAD_BEEF_0000_1234, 1, 0);
    add_vec(4'h0, 1'b1, 64'h4A, 64'h4B, 64'h4C, 64'hDEAD_BEEF_0000_1234, 1, 0);
    add_vec(4'h6, 1'bx, 64'h4D, 64'h8000_0000_0000_0000, 64'h4E, 64'h8000_0000_0000_0000, 0, 0);
    add_vec(4'h7, 1'b0, 64'h5, 64'h7FFF_FFFF_FFFF_FFFF, 64'h4F, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    add_vec(4'h2, 1'b1, 64'h50, 64'h48, 64'h51, 64'h48, 0, 0);
    add_vec(4'h4, 1'b0, 64'h53, 64'h52, 64'h54, 64'h52, 0, 0);
    add_vec(4'h5, 1'b1, 64'h55, 64'h5C, 64'h56, 64'h5C, 0, 0);
    add_vec(4'hD, 1'b1, 64'h57, 64'h58, 64'h59, 64'h5C, 0, 1);
    add_vec(4'h9, 1'bx, 64'h5A, 64'h5B, 64'h1234, 64'h1234, 0, 0);

    // Reset held while a taken jump is presented and clk toggles.
    rst_n = 1'b0; icode = 4'h7; cnd = 1'b1;
    valC = 64'h40; valP = 64'h09; valM = 64'h0;
    #1 check_reset_state("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_reset_state($sformatf("reset_hold%0d", i));
    end
    // Halt and invalid opcodes during reset must not set the flags.
    icode = 4'h0;
    @(posedge clk);
    #1 check_reset_state("reset_halt_icode");
    icode = 4'hE;
    @(posedge clk);
    #1 check_reset_state("reset_bad_icode");

    // Release: first edge loads valC of the taken jump.
    last_pc = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h7, 1'b1, 64'h40, 64'h09, 64'h0, 64'h40, 0, 0, 100);
    step();

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].icode, vecs[i].cnd, vecs[i].valC, vecs[i].valP, vecs[i].valM,
            vecs[i].exp_pc, vecs[i].exp_halted, vecs[i].exp_err, i);
      step();
    end

    // Randomised instructions against a reference model of the selection.
    for (int i = 0; i < 40; i++) begin
      r_ic = 4'($urandom_range(0, 15));
      r_c  = 1'($urandom_range(0, 1));
      r_vc = {$urandom, $urandom};
      r_vp = {$urandom, $urandom};
      r_vm = {$urandom, $urandom};
      r_h  = (r_ic == 4'h0);
      r_e  = (r_ic >= 4'hC);
      if (r_ic == 4'h7)      r_pc = r_c ? r_vc : r_vp;
      else if (r_ic == 4'h8) r_pc = r_vc;
      else if (r_ic == 4'h9) r_pc = r_vm;
      else if (r_h || r_e)   r_pc = last_pc;
      else                   r_pc = r_vp;
      drive(r_ic, r_c, r_vc, r_vp, r_vm, r_pc, r_h, r_e, 1000 + i);
      step();
    end

    // Asynchronous reset mid-cycle while halted is set.
    drive(4'h0, 1'b0, 64'h61, 64'h62, 64'h63, last_pc, 1, 0, 200);
    step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midcycle_reset");
    @(posedge clk);
    #1 check_reset_state("midcycle_reset_edge");

    // Release and resume with a plain sequential instruction.
    last_pc = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h1, 1'b0, 64'h71, 64'h50, 64'h72, 64'h50, 0, 0, 300);
    step();

    // Invalid opcode sets the error flag, then reset lands on a clock edge.
    drive(4'hD, 1'b1, 64'h81, 64'h82, 64'h83, 64'h50, 0, 1, 400);
    step();
    @(negedge clk);
    icode = 4'h8; valC = 64'h90;
    @(posedge clk);
    rst_n = 1'b0;
    #1 check_reset_state("reset_on_edge");
    @(negedge clk);
    rst_n = 1'b1;

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_update.md
Name: pc_update

Overview:
- PC-update stage of the sequential Y86-64 processor.
- Selects the next program counter from icode, the branch condition (cnd) and the stage values valC, valP and valM.
- Registers the selected value as the architectural PC on each rising clock edge.
- Sits after write-back; its output pcnxt feeds the fetch stage.

Parameters:
- WIDTH, 64, width of the PC and of valC/valP/valM.
- RESET_PC, 0, value loaded into pcnxt while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- icode  input  4  instruction code of the current instruction.
- cnd  input  1  condition flag from execute; used only by jXX.
- valC  input  WIDTH  instruction constant (jump/call target).
- valP  input  WIDTH  address of the sequentially next instruction.
- valM  input  WIDTH  value read from memory (return address for ret).
- pcnxt  output  WIDTH  registered program counter.
- halted  output  1  registered; high when the last captured instruction was halt.
- instr_err  output  1  registered; high when the last captured icode was invalid.

Behaviour:
- Reset
  - rst_n low asynchronously forces pcnxt=RESET_PC, halted=0, instr_err=0.
  - Takes effect immediately, independent of clk.
  - Release is synchronous-safe: the first update occurs on the first rising clk edge with rst_n high.
- Next-PC selection, combinational, evaluated from current inputs:
  - icode 0x0 (halt): next = current pcnxt (PC holds); halted_next=1.
  - icode 0x1–0x6, 0xA, 0xB (nop, cmovXX, irmovq, rmmovq, mrmovq, OPq, pushq, popq): next = valP.
  - icode 0x7 (jXX): next = valC if cnd=1, else valP.
  - icode 0x8 (call): next = valC; cnd ignored.
  - icode 0x9 (ret): next = valM; cnd ignored.
  - icode 0xC–0xF (invalid): next = current pcnxt (hold); instr_err_next=1.
  - cnd is don't-care for every icode other than 0x7; X on cnd must not propagate for those icodes.
- Register update on each rising clk edge with rst_n high:
  - pcnxt <= next.
  - halted <= (icode==0).
  - instr_err <= (icode>=0xC).
- halted and instr_err are not sticky: a valid non-halt icode on the next edge clears them. The control unit is responsible for stopping the machine.
- Latency: one clock edge from input change to pcnxt change. pcnxt is stable between edges and never changes combinationally except on reset.
- Arithmetic: pure selection, no addition; values pass through unmodified at full WIDTH, no truncation or sign handling.
- Simultaneous events: a reset assertion coinciding with a clock edge wins; pcnxt=RESET_PC.
- Reset mid-operation: clears pcnxt and both flags regardless of icode.

Test Plan:
- Reset: rst_n=0 with icode=0x7, cnd=1, valC=0x40, toggling clk -> pcnxt=0, halted=0, instr_err=0 throughout. Release rst_n -> first edge loads 0x40.
- Sequential: icode=0x1, valP=0x0A, edge -> pcnxt=0x0A. Then icode=0xA, valP=0x0C, edge -> pcnxt=0x0C.
- Jump: icode=0x7, valC=0x100, valP=0x09, cnd=1, edge -> pcnxt=0x100. cnd=0, edge -> pcnxt=0x09.
- Call/ret: icode=0x8, valC=0x200, cnd=0, edge -> pcnxt=0x200. Then icode=0x9, valM=0x13, edge -> pcnxt=0x13.
- Halt/invalid: from pcnxt=0x13, icode=0x0, valP=0x14, edge -> pcnxt=0x13, halted=1. icode=0xE, edge -> pcnxt=0x13, instr_err=1, halted=0. icode=0x1, valP=0x20, edge -> pcnxt=0x20, both flags 0.
- Full width: icode=0x9, valM=0xFFFF_FFFF_FFFF_FFF8, edge -> pcnxt equals that value exactly.
